// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 multiplexing arbiter with a one-deep registered output stage.
// Optional transfer counter enabled by defining RR_MUX_ARBITER_XFER_CNT_EN.
module rr_mux_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [2**SEL_WIDTH-1:0]                 req,
  input  logic [(2**SEL_WIDTH)*DATA_WIDTH-1:0]    data,
  output logic [2**SEL_WIDTH-1:0]                 grant,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH-1:0]                   out_data,
  output logic [SEL_WIDTH-1:0]                    out_sel,
  output logic [7:0]                              xfer_cnt
);

  localparam int N = 2**SEL_WIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]            state;
  logic [SEL_WIDTH-1:0]  last_sel;

  logic                  win_found;
  logic [SEL_WIDTH-1:0]  win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  capture;
  logic                  done;

  // Round-robin search: start just after the previous winner, wrap around.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_sel) + k) % N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = SEL_WIDTH'(idx);
        win_data  = data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The output register can load when empty or when it drains this same cycle.
  // rst_n gates the capture so no grant leaks out while reset is held.
  assign capture   = rst_n && win_found && ((state == IDLE) || out_ready);
  assign done      = (state == BUSY) && out_ready;
  assign grant     = capture ? (N'(1) << win_idx) : '0;
  assign out_valid = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state    <= IDLE;
      out_data <= '0;
      out_sel  <= '0;
      last_sel <= SEL_WIDTH'(N - 1);
    end else if (capture) begin
      state    <= BUSY;
      out_data <= win_data;
      out_sel  <= win_idx;
      last_sel <= win_idx;
    end else if (done) begin
      state    <= IDLE;
    end
  end

`ifdef RR_MUX_ARBITER_XFER_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (done) cnt_q <= cnt_q + 8'd1;
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a per-cycle reference model predicts grants
// and queues expected transfers; an independent monitor pops them at each handshake.
module tb_rr_mux_arbiter;

  localparam int DW = 8;
  localparam int SW = 2;
  localparam int N  = 2**SW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   data = '0;
  logic [N-1:0]      grant;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_sel;
  logic [7:0]        xfer_cnt;

  rr_mux_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [DW-1:0] dat;
  } xfer_t;

  xfer_t exp_q[$];

  int tests  = 0;
  int errors = 0;

  // Reference model state
  bit m_busy = 1'b0;
  int m_last = N - 1;
  int m_cnt  = 0;
  int m_win  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_xfer(input int cnt);
`ifdef RR_MUX_ARBITER_XFER_CNT_EN
    return 8'(cnt % 256);
`else
    return 8'(cnt * 0);
`endif
  endfunction

  // One clock of stimulus: drive after the rising edge, check on the falling edge,
  // then advance the model to what the next rising edge should produce.
  task automatic drive(input logic [N-1:0] r, input logic [N*DW-1:0] dv, input bit rdy, input bit rst);
    logic [N-1:0] exp_g;
    @(posedge clk);
    #1;
    rst_n     = !rst;
    req       = r;
    data      = dv;
    out_ready = rdy;
    @(negedge clk);

    exp_g = '0;
    m_win = -1;
    if (!rst && r != '0 && (!m_busy || rdy)) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (m_win < 0 && r[idx]) m_win = idx;
      end
      exp_g[m_win] = 1'b1;
    end

    check("grant", 32'(grant), 32'(exp_g));
    check("out_valid", 32'(out_valid), 32'(m_busy && !rst));
    check("xfer_cnt", 32'(xfer_cnt), 32'(rst ? 8'd0 : exp_xfer(m_cnt)));
    if (rst) begin
      check("rst_out_sel", 32'(out_sel), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
    end else if (m_busy) begin
      check("hold_out_sel", 32'(out_sel), 32'(exp_q[0].sel));
      check("hold_out_data", 32'(out_data), 32'(exp_q[0].dat));
    end

    if (rst) begin
      m_busy = 1'b0;
      m_last = N - 1;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      if (m_busy && rdy) m_cnt++;
      if (m_win >= 0) begin
        xfer_t t;
        t.sel = m_win;
        t.dat = dv[m_win*DW +: DW];
        exp_q.push_back(t);
        m_busy = 1'b1;
        m_last = m_win;
      end else if (m_busy && rdy) begin
        m_busy = 1'b0;
      end
    end
  endtask

  // Monitor: compares every completed handshake against the oldest expected transfer.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 32'(out_valid), 32'd0);
        end else begin
          xfer_t t;
          t = exp_q.pop_front();
          check("xfer_sel", 32'(out_sel), 32'(t.sel));
          check("xfer_data", 32'(out_data), 32'(t.dat));
        end
      end
    end
  end

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  initial begin
    logic [N*DW-1:0] dv;
    bit              pend [N];
    logic [DW-1:0]   pdat [N];
    logic [N-1:0]    r;

    // Reset with random requests: nothing may be granted or presented.
    for (int i = 0; i < 4; i++) drive(N'($urandom), rand_data(), 1'($urandom), 1'b1);
    drive('0, rand_data(), 1'b1, 1'b0);

    // Single request on channel 2 carrying 0xA5.
    dv = rand_data();
    dv[2*DW +: DW] = 8'hA5;
    drive(4'b0100, dv, 1'b1, 1'b0);
    check("single_grant", 32'(grant), 32'h4);
    drive('0, rand_data(), 1'b1, 1'b0);
    check("single_sel", 32'(out_sel), 32'd2);
    check("single_data", 32'(out_data), 32'hA5);
    drive('0, rand_data(), 1'b1, 1'b0);

    // Fairness from reset: all four requesting, rotation 0,1,2,3,0,1,2,3.
    drive('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, rand_data(), 1'b1, 1'b0);
      check("fair_rotation", 32'(grant), 32'(4'b0001 << (i % N)));
    end
    drive('0, rand_data(), 1'b1, 1'b0);
    drive('0, rand_data(), 1'b1, 1'b0);

    // Backpressure: first capture, five stalled cycles, then release grants channel 1.
    drive(4'b1000, rand_data(), 1'b1, 1'b0);
    drive('0, rand_data(), 1'b1, 1'b0);
    drive(4'b0011, rand_data(), 1'b0, 1'b0);
    check("bp_first_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0011, rand_data(), 1'b0, 1'b0);
      check("bp_stall_grant", 32'(grant), 32'h0);
      check("bp_stall_sel", 32'(out_sel), 32'd0);
    end
    drive(4'b0011, rand_data(), 1'b1, 1'b0);
    check("bp_release_grant", 32'(grant), 32'h2);
    drive('0, rand_data(), 1'b1, 1'b0);
    drive('0, rand_data(), 1'b1, 1'b0);

    // Wrap and drain: last winner 3, then channel 0, then back to idle.
    drive(4'b1000, rand_data(), 1'b1, 1'b0);
    drive(4'b0001, rand_data(), 1'b1, 1'b0);
    check("wrap_grant", 32'(grant), 32'h1);
    drive('0, rand_data(), 1'b1, 1'b0);
    drive('0, rand_data(), 1'b1, 1'b0);
    check("drain_idle", 32'(out_valid), 32'd0);

    // Reset in the middle of a stalled transfer abandons it.
    drive(4'b0110, rand_data(), 1'b0, 1'b0);
    drive(4'b0110, rand_data(), 1'b0, 1'b0);
    drive(4'b0110, rand_data(), 1'b1, 1'b1);
    drive('0, rand_data(), 1'b1, 1'b0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);

    // Randomized traffic: requesters hold req and data until they see their grant.
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pdat[i] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          pdat[i] = DW'($urandom);
        end
      end
      r  = '0;
      dv = rand_data();
      for (int i = 0; i < N; i++) begin
        r[i] = pend[i];
        if (pend[i]) dv[i*DW +: DW] = pdat[i];
      end
      drive(r, dv, ($urandom_range(0, 3) != 0), 1'b0);
      if (m_win >= 0) pend[m_win] = 1'b0;
    end
    drive('0, rand_data(), 1'b1, 1'b0);
    drive('0, rand_data(), 1'b1, 1'b0);

    // Counter wrap: exactly 257 completed transfers after reset.
    drive('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 257; i++) drive(4'b1111, rand_data(), 1'b1, 1'b0);
    drive('0, rand_data(), 1'b1, 1'b0);
    drive('0, rand_data(), 1'b1, 1'b0);
`ifdef RR_MUX_ARBITER_XFER_CNT_EN
    check("cnt_257", 32'(xfer_cnt), 32'd1);
`else
    check("cnt_257", 32'(xfer_cnt), 32'd0);
`endif
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
